// File: rtl/mmio_io_hub.sv
// +----------------------------------------------------------------------------+
// | mmio_io_hub : memory-mapped hub for buffered input channels, output regs,  |
// |               sticky bus-fault capture and a level interrupt.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module mmio_io_hub #(
  parameter int            AW         = 12,
  parameter int            DW         = 16,
  parameter int            N_IN       = 2,
  parameter int            FIFO_DEPTH = 4,
  parameter int            N_OUT      = 2,
  parameter logic [AW-1:0] IO_BASE    = 12'h900,
  parameter logic [AW-1:0] OUT_BASE   = 12'hb00
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       address,
  input  logic [DW-1:0]       cpu_wdata,
  input  logic                memwt,
  input  logic                rd,
  output logic                hub_sel,
  output logic [DW-1:0]       hub_rdata,
  input  logic [N_IN*DW-1:0]  in_data,
  input  logic [N_IN-1:0]     in_valid,
  output logic [N_OUT*DW-1:0] out_regs,
  output logic                irq
);

  localparam int            c_PW       = $clog2(FIFO_DEPTH);
  localparam int            c_CW       = c_PW + 1;
  localparam logic [DW-1:0] c_UNMAPPED = DW'(16'hF345);

  // Both windows are 256-aligned, so a window hit is an upper-bit match.
  logic       w_io_hit;
  logic       w_out_hit;
  logic [7:0] w_off;
  logic       w_rd_only;
  logic       w_fault_sel;
  logic       w_fault_clr;
  logic       w_mapped;
  logic       w_unmapped_acc;

  logic [N_IN-1:0]          w_data_sel;
  logic [N_IN-1:0]          w_stat_sel;
  logic [N_IN-1:0]          w_irq_src;
  logic [N_IN-1:0][DW-1:0]  w_head;
  logic [N_IN-1:0][DW-1:0]  w_stat;
  logic [N_OUT-1:0]         w_out_sel;
  logic [N_OUT-1:0][DW-1:0] r_out;

  logic          r_fault;
  logic [AW-1:0] r_fault_addr;
  logic          r_irq;
  logic [DW-1:0] w_rdata;

  assign w_io_hit    = (address[AW-1:8] == IO_BASE[AW-1:8]);
  assign w_out_hit   = (address[AW-1:8] == OUT_BASE[AW-1:8]);
  assign w_off       = address[7:0];
  assign hub_sel     = w_io_hit | w_out_hit;
  assign w_rd_only   = rd & ~memwt;
  assign w_fault_sel = w_io_hit & (w_off == 8'hFF);
  assign w_fault_clr = w_fault_sel & w_rd_only;

  assign w_mapped       = w_fault_sel | (|w_data_sel) | (|w_stat_sel) | (|w_out_sel);
  assign w_unmapped_acc = hub_sel & ~w_mapped & (rd | memwt);

  generate
    for (genvar i = 0; i < N_IN; i++) begin : g_ch
      logic [DW-1:0]   r_mem [FIFO_DEPTH];
      logic [c_PW-1:0] r_rd_ptr;
      logic [c_PW-1:0] r_wr_ptr;
      logic [c_CW-1:0] r_count;
      logic            r_ovf;
      logic            r_ie;
      logic            w_ne;
      logic            w_full;
      logic            w_pop;
      logic            w_drop;
      logic            w_push;
      logic            w_stat_wr;

      assign w_data_sel[i] = w_io_hit & (w_off == 8'(2 * i));
      assign w_stat_sel[i] = w_io_hit & (w_off == 8'(2 * i + 1));

      assign w_ne      = (r_count != '0);
      assign w_full    = (r_count == c_CW'(FIFO_DEPTH));
      assign w_pop     = w_rd_only & w_data_sel[i] & w_ne;
      // A pop in the same cycle frees the slot the push is about to use.
      assign w_drop    = in_valid[i] & w_full & ~w_pop;
      assign w_push    = in_valid[i] & ~w_drop;
      assign w_stat_wr = memwt & w_stat_sel[i];

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= in_data[i*DW +: DW];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_ptr <= '0;
          r_wr_ptr <= '0;
          r_count  <= '0;
          r_ovf    <= 1'b0;
          r_ie     <= 1'b0;
        end else begin
          if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
          if (w_push && !w_pop)      r_count <= r_count + 1'b1;
          else if (w_pop && !w_push) r_count <= r_count - 1'b1;
          // A fresh overflow outranks a simultaneous software clear.
          if (w_drop)                         r_ovf <= 1'b1;
          else if (w_stat_wr && cpu_wdata[2]) r_ovf <= 1'b0;
          if (w_stat_wr) r_ie <= cpu_wdata[3];
        end
      end

      assign w_head[i]    = w_ne ? r_mem[r_rd_ptr] : '0;
      assign w_stat[i]    = DW'({5'(r_count), r_ie, r_ovf, w_full, w_ne});
      assign w_irq_src[i] = w_ne & r_ie;
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
      assign w_out_sel[j] = w_out_hit & (w_off == 8'(j));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out[j] <= '0;
        end else if (memwt && w_out_sel[j]) begin
          r_out[j] <= cpu_wdata;
        end
      end
    end
  endgenerate

  // First fault is held until read-cleared; a new fault on the clearing edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_irq        <= 1'b0;
    end else begin
      if (w_unmapped_acc && (!r_fault || w_fault_clr)) begin
        r_fault      <= 1'b1;
        r_fault_addr <= address;
      end else if (w_fault_clr) begin
        r_fault      <= 1'b0;
        r_fault_addr <= '0;
      end
      r_irq <= |w_irq_src;
    end
  end

  always_comb begin
    w_rdata = c_UNMAPPED;
    if (w_fault_sel) begin
      w_rdata           = '0;
      w_rdata[DW-1]     = r_fault;
      w_rdata[AW-1:0]   = r_fault_addr;
    end
    for (int i = 0; i < N_IN; i++) begin
      if (w_data_sel[i]) w_rdata = w_head[i];
      if (w_stat_sel[i]) w_rdata = w_stat[i];
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (w_out_sel[j]) w_rdata = r_out[j];
    end
  end

  assign hub_rdata = w_rdata;
  assign out_regs  = r_out;
  assign irq       = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_mmio_io_hub.sv
// Testbench for mmio_io_hub: directed scenarios followed by randomized traffic
// checked against a queue-based reference model.
`default_nettype none

module tb_mmio_io_hub;

  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int DEPTH = 4;

  localparam int K_NONE  = 0;
  localparam int K_UNMAP = 1;
  localparam int K_DATA  = 2;
  localparam int K_STAT  = 3;
  localparam int K_FAULT = 4;
  localparam int K_OUT   = 5;

  logic        clk;
  logic        rst_n;
  logic [11:0] address;
  logic [15:0] cpu_wdata;
  logic        memwt;
  logic        rd;
  logic        hub_sel;
  logic [15:0] hub_rdata;
  logic [31:0] in_data;
  logic [1:0]  in_valid;
  logic [31:0] out_regs;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          m_ovf [N_IN];
  bit          m_ie  [N_IN];
  logic [15:0] m_out [N_OUT];
  bit          m_fault;
  logic [11:0] m_faddr;
  bit          m_irq;

  mmio_io_hub dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .cpu_wdata (cpu_wdata),
    .memwt     (memwt),
    .rd        (rd),
    .hub_sel   (hub_sel),
    .hub_rdata (hub_rdata),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_regs  (out_regs),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [11:0] a);
    int o;
    if (a >= 12'h900 && a <= 12'h9FF) begin
      o = int'(a) - 'h900;
      if (o == 255) return K_FAULT;
      if (o < 2 * N_IN) return (o % 2 == 0) ? K_DATA : K_STAT;
      return K_UNMAP;
    end
    if (a >= 12'hB00 && a <= 12'hBFF) begin
      o = int'(a) - 'hB00;
      return (o < N_OUT) ? K_OUT : K_UNMAP;
    end
    return K_NONE;
  endfunction

  function automatic int idx_of(input logic [11:0] a);
    if (a >= 12'h900 && a <= 12'h9FF) return (int'(a) - 'h900) / 2;
    return int'(a) - 'hB00;
  endfunction

  function automatic int qsize(input int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [15:0] qhead(input int ch);
    if (qsize(ch) == 0) return 16'h0000;
    return (ch == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic [15:0] model_rdata(input logic [11:0] a);
    int ch;
    ch = idx_of(a);
    case (kind_of(a))
      K_DATA:  return qhead(ch);
      K_STAT:  return {7'b0, 5'(qsize(ch)), m_ie[ch], m_ovf[ch],
                       qsize(ch) == DEPTH, qsize(ch) != 0};
      K_FAULT: return {m_fault, 3'b000, m_faddr};
      K_OUT:   return m_out[ch];
      default: return 16'hF345;
    endcase
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < N_IN; i++) begin
      m_ovf[i] = 0;
      m_ie[i]  = 0;
    end
    for (int j = 0; j < N_OUT; j++) m_out[j] = 16'h0000;
    m_fault = 0;
    m_faddr = 12'h000;
    m_irq   = 0;
  endtask

  task automatic model_edge(input logic [11:0] a, input logic [15:0] wd, input logic w,
                            input logic r, input logic [1:0] iv, input logic [31:0] idat);
    bit new_irq, rd_only, clr, newf, popped, ovf_ev;
    int k, ix;
    new_irq = (q0.size() > 0 && m_ie[0]) || (q1.size() > 0 && m_ie[1]);
    k       = kind_of(a);
    ix      = idx_of(a);
    rd_only = r && !w;
    clr     = (k == K_FAULT) && rd_only;
    newf    = (k == K_UNMAP) && (w || r);
    if (newf && (!m_fault || clr)) begin
      m_fault = 1;
      m_faddr = a;
    end else if (clr) begin
      m_fault = 0;
      m_faddr = 12'h000;
    end
    for (int ch = 0; ch < N_IN; ch++) begin
      popped = rd_only && k == K_DATA && ix == ch && qsize(ch) > 0;
      ovf_ev = 0;
      if (popped) begin
        if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (iv[ch]) begin
        if (qsize(ch) == DEPTH) ovf_ev = 1;
        else if (ch == 0) q0.push_back(idat[15:0]);
        else q1.push_back(idat[31:16]);
      end
      if (w && k == K_STAT && ix == ch) begin
        if (wd[2]) m_ovf[ch] = 0;
        m_ie[ch] = wd[3];
      end
      if (ovf_ev) m_ovf[ch] = 1;
    end
    if (w && k == K_OUT) m_out[ix] = wd;
    m_irq = new_irq;
  endtask

  // One bus cycle: drive, check combinational read side, clock, check registered side.
  task automatic cycle(input logic [11:0] a, input logic [15:0] wd, input logic w,
                       input logic r, input logic [1:0] iv, input logic [31:0] idat,
                       output logic [15:0] got);
    address = a; cpu_wdata = wd; memwt = w; rd = r; in_valid = iv; in_data = idat;
    #1;
    got = hub_rdata;
    check("rdata", hub_rdata, model_rdata(a));
    check("hub_sel", hub_sel, kind_of(a) != K_NONE);
    @(posedge clk);
    model_edge(a, wd, w, r, iv, idat);
    #1;
    check("irq", irq, m_irq);
    check("out_regs", out_regs, {m_out[1], m_out[0]});
  endtask

  initial begin
    logic [15:0] g;
    logic [11:0] picks [10];
    int          pk;
    picks = '{12'h900, 12'h901, 12'h902, 12'h903, 12'h9FF,
              12'h904, 12'hB00, 12'hB01, 12'hB05, 12'h123};

    rst_n = 1'b0; address = 12'h000; cpu_wdata = 16'h0; memwt = 0; rd = 0;
    in_valid = 2'b00; in_data = 32'h0;
    model_reset();
    #1;
    check("rst_out_regs", out_regs, 32'h0);
    check("rst_irq", irq, 1'b0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    cycle(12'h901, 16'h0, 0, 1, 2'b00, 32'h0, g); check("rst_status0", g, 16'h0000);
    cycle(12'h900, 16'h0, 0, 1, 2'b00, 32'h0, g); check("rst_data0", g, 16'h0000);

    cycle(12'h000, 16'h0, 0, 0, 2'b01, 32'h0000_00A5, g);
    cycle(12'h000, 16'h0, 0, 0, 2'b01, 32'h0000_005A, g);
    cycle(12'h901, 16'h0, 0, 1, 2'b00, 32'h0, g); check("status_two", g, 16'h0021);
    cycle(12'h900, 16'h0, 0, 1, 2'b00, 32'h0, g); check("pop_a5", g, 16'h00A5);
    cycle(12'h900, 16'h0, 0, 1, 2'b00, 32'h0, g); check("pop_5a", g, 16'h005A);
    cycle(12'h901, 16'h0, 0, 1, 2'b00, 32'h0, g); check("status_empty", g, 16'h0000);

    for (int v = 1; v <= 5; v++) cycle(12'h000, 16'h0, 0, 0, 2'b01, 32'(v), g);
    cycle(12'h901, 16'h0, 0, 1, 2'b00, 32'h0, g); check("status_ovf", g, 16'h0047);
    for (int v = 1; v <= 4; v++) begin
      cycle(12'h900, 16'h0, 0, 1, 2'b00, 32'h0, g); check("pop_seq", g, 16'(v));
    end
    cycle(12'h901, 16'h0004, 1, 0, 2'b00, 32'h0, g);
    cycle(12'h901, 16'h0, 0, 1, 2'b00, 32'h0, g); check("ovf_cleared", g, 16'h0000);

    for (int v = 0; v < 4; v++) cycle(12'h000, 16'h0, 0, 0, 2'b10, {16'(16'h10 + v), 16'h0}, g);
    cycle(12'h902, 16'h0, 0, 1, 2'b10, {16'h0077, 16'h0}, g); check("full_pushpop", g, 16'h0010);
    cycle(12'h903, 16'h0, 0, 1, 2'b00, 32'h0, g); check("full_status", g, 16'h0043);
    for (int v = 1; v < 4; v++) begin
      cycle(12'h902, 16'h0, 0, 1, 2'b00, 32'h0, g); check("pop_ch1", g, 16'(16'h10 + v));
    end
    cycle(12'h902, 16'h0, 0, 1, 2'b00, 32'h0, g); check("pop_77", g, 16'h0077);

    cycle(12'hB00, 16'h1234, 1, 0, 2'b00, 32'h0, g);
    cycle(12'hB01, 16'hBEEF, 1, 0, 2'b00, 32'h0, g);
    check("out_pair", out_regs, 32'hBEEF_1234);
    cycle(12'hB00, 16'h0, 0, 1, 2'b00, 32'h0, g); check("read_out0", g, 16'h1234);

    cycle(12'hB05, 16'h0, 1, 0, 2'b00, 32'h0, g);
    cycle(12'h9FF, 16'h0, 0, 1, 2'b00, 32'h0, g); check("fault_rd", g, 16'h8B05);
    cycle(12'h9FF, 16'h0, 0, 1, 2'b00, 32'h0, g); check("fault_clr", g, 16'h0000);

    cycle(12'h901, 16'h0008, 1, 0, 2'b00, 32'h0, g);
    cycle(12'h000, 16'h0, 0, 0, 2'b01, 32'h0000_0042, g); check("irq_lat0", irq, 1'b0);
    cycle(12'h000, 16'h0, 0, 0, 2'b00, 32'h0, g);         check("irq_set", irq, 1'b1);
    cycle(12'h900, 16'h0, 1, 1, 2'b00, 32'h0, g);         check("rdwr_no_pop", irq, 1'b1);
    cycle(12'h900, 16'h0, 0, 1, 2'b00, 32'h0, g);         check("pop_irq", g, 16'h0042);
    check("irq_hold", irq, 1'b1);
    cycle(12'h000, 16'h0, 0, 0, 2'b00, 32'h0, g);         check("irq_clr", irq, 1'b0);

    cycle(12'h000, 16'h0, 0, 0, 2'b01, 32'h0000_0099, g);
    cycle(12'h000, 16'h0, 0, 0, 2'b00, 32'h0, g);
    check("irq_pre_reset", irq, 1'b1);
    #2;
    rst_n = 1'b0; address = 12'h901;
    #1;
    check("async_irq", irq, 1'b0);
    check("async_out", out_regs, 32'h0);
    check("async_status", hub_rdata, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      pk = $urandom_range(0, 11);
      cycle((pk < 10) ? picks[pk] : 12'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
            2'($urandom_range(0, 3) & $urandom_range(0, 3)), $urandom, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
